// File: rtl/iopmp_pkg.sv
// Shared types and constants for the IOPMP rule checker and its entry matcher.
package iopmp_pkg;

   typedef enum logic [1:0] {
      CHK_IDLE = 2'd0,
      CHK_SCAN = 2'd1,
      CHK_RESP = 2'd2
   } chk_state_e;

   localparam logic [3:0] ETYPE_READ         = 4'd1;
   localparam logic [3:0] ETYPE_WRITE        = 4'd2;
   localparam logic [3:0] ETYPE_EXEC         = 4'd3;
   localparam logic [3:0] ETYPE_PARTIAL      = 4'd4;
   localparam logic [3:0] ETYPE_NO_HIT       = 4'd5;
   localparam logic [3:0] ETYPE_UNKNOWN_RRID = 4'd6;

   localparam logic [1:0] TTYPE_READ  = 2'd1;
   localparam logic [1:0] TTYPE_WRITE = 2'd2;
   localparam logic [1:0] TTYPE_EXEC  = 2'd3;

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_TOR   = 2'd1;
   localparam logic [1:0] MODE_NA4   = 2'd2;
   localparam logic [1:0] MODE_NAPOT = 2'd3;

   typedef struct packed {
      logic [1:0] a;
      logic       x;
      logic       w;
      logic       r;
   } entry_cfg_t;

   typedef struct packed {
      logic [1:0]  ttype;
      logic [3:0]  etype;
      logic [15:0] rrid;
      logic [15:0] eid;
      logic [33:0] addr;
   } error_registers_t;

   // Request type 3 is reported as a read.
   function automatic logic [1:0] ttype_of(input logic [1:0] t);
      case (t)
         2'd1:    return TTYPE_WRITE;
         2'd2:    return TTYPE_EXEC;
         default: return TTYPE_READ;
      endcase
   endfunction

   // log2 of the NAPOT region size: trailing ones counted from bit 2, plus 3.
   function automatic logic [5:0] napot_log2(input logic [33:0] e);
      logic [5:0] k;
      logic       run;
      k   = 6'd3;
      run = 1'b1;
      for (int i = 2; i < 34; i++) begin
         if (run && e[i]) k = k + 6'd1;
         else             run = 1'b0;
      end
      return k;
   endfunction

endpackage

// File: rtl/iopmp_entry_match.sv
// Combinational single-entry matcher: classifies an access as a full or partial hit.
module iopmp_entry_match
   import iopmp_pkg::*;
(
   input  logic [1:0]  mode,
   input  logic [33:0] e,
   input  logic [33:0] e_prev,
   input  logic [33:0] addr,
   input  logic [1:0]  size,
   output logic        full_hit,
   output logic        partial_hit
);

   logic [35:0] lo, hi, first, last, span;
   logic        first_in, last_in;

   // Bounds carry two spare bits so a 2^35 NAPOT region cannot wrap.
   always_comb begin
      first = {2'b00, addr};
      last  = first + (36'd1 << size) - 36'd1;
      span  = 36'd1 << napot_log2(e);
      lo    = '0;
      hi    = '0;
      case (mode)
         MODE_TOR:   begin lo = {2'b00, e_prev}; hi = {2'b00, e}; end
         MODE_NA4:   begin lo = {2'b00, e}; hi = {2'b00, e} + 36'd4; end
         MODE_NAPOT: begin lo = {2'b00, e} & ~(span - 36'd1); hi = lo + span; end
         default:    ;
      endcase
      first_in = (first >= lo) && (first < hi);
      // A last byte beyond the 34-bit space is never inside a region.
      last_in  = !last[34] && (last >= lo) && (last < hi);
   end

   assign full_hit    = (mode != MODE_OFF) && first_in && last_in;
   assign partial_hit = (mode != MODE_OFF) && (first_in ^ last_in);

endmodule

// File: rtl/iopmp_rule_checker.sv
// Sequential IOPMP rule checker: scans one entry per cycle, returns allow/deny and an error record.
// Optional IOPMP_CHK_EARLY_EXIT_EN ends the scan at the first decisive entry.
module iopmp_rule_checker
   import iopmp_pkg::*;
#(
   parameter  int IOPMPRegions       = 16,
   parameter  int IOPMPMemoryDomains = 8,
   parameter  int NUM_MASTERS        = 4,
   localparam int RRID_W             = $clog2(NUM_MASTERS) + 1
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    req_valid_i,
   output logic                                    req_ready_o,
   input  logic [RRID_W-1:0]                       req_rrid_i,
   input  logic [33:0]                             req_addr_i,
   input  logic [1:0]                              req_size_i,
   input  logic [1:0]                              req_type_i,
   input  entry_cfg_t [IOPMPRegions-1:0]           entry_conf_table,
   input  logic [IOPMPRegions-1:0][33:0]           entry_addr_table,
   input  logic [IOPMPMemoryDomains-1:0][15:0]     mdcfg_table,
   input  logic [NUM_MASTERS-1:0][31:0]            srcmd_en_table,
   input  logic [15:0]                             prio_entry_num,
   output logic                                    busy_o,
   output logic                                    rsp_valid_o,
   input  logic                                    rsp_ready_i,
   output logic                                    rsp_allow_o,
   output logic                                    err_valid_o,
   output error_registers_t                        error_report_o
);

   localparam int IDX_W  = (IOPMPRegions > 1) ? $clog2(IOPMPRegions) : 1;
   localparam int MIDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(IOPMPRegions - 1);
   localparam logic [RRID_W-1:0] RRID_LIMIT = RRID_W'(NUM_MASTERS);

   chk_state_e        state;
   logic [IDX_W-1:0]  idx;
   logic [RRID_W-1:0] rrid_q;
   logic [33:0]       addr_q;
   logic [1:0]        size_q, type_q;
   logic              decided, dec_allow, npd_found, rsp_allow;
   logic [3:0]        dec_etype, npd_etype;
   logic [15:0]       dec_eid, npd_eid;
   error_registers_t  err_rep;

   entry_cfg_t  cfg;
   logic [33:0] e_cur, e_prev;
   logic        full_hit, partial_hit, md_hit, md_en, perm_ok, entry_on, is_prio;
   logic        dec_now, now_allow, np_deny, scan_done, fin_allow;
   logic [3:0]  perm_etype, now_etype, fin_etype;
   logic [15:0] fin_eid;
   logic        unused_tables;

   assign cfg    = entry_conf_table[idx];
   assign e_cur  = entry_addr_table[idx];
   assign e_prev = (idx == '0) ? '0 : entry_addr_table[idx - IDX_W'(1)];

   iopmp_entry_match u_match (
      .mode        (cfg.a),
      .e           (e_cur),
      .e_prev      (e_prev),
      .addr        (addr_q),
      .size        (size_q),
      .full_hit    (full_hit),
      .partial_hit (partial_hit)
   );

   // An entry belongs to the first MD whose top index lies above it.
   always_comb begin
      md_hit = 1'b0;
      md_en  = 1'b0;
      for (int m = 0; m < IOPMPMemoryDomains; m++) begin
         if (!md_hit && (16'(idx) < mdcfg_table[m])) begin
            md_hit = 1'b1;
            md_en  = srcmd_en_table[rrid_q[MIDX_W-1:0]][m+1];
         end
      end
      case (type_q)
         2'd1:    begin perm_ok = cfg.w; perm_etype = ETYPE_WRITE; end
         2'd2:    begin perm_ok = cfg.x; perm_etype = ETYPE_EXEC;  end
         default: begin perm_ok = cfg.r; perm_etype = ETYPE_READ;  end
      endcase
   end

   assign entry_on  = md_hit && md_en && (cfg.a != MODE_OFF);
   assign is_prio   = 16'(idx) < prio_entry_num;
   assign dec_now   = !decided && entry_on &&
                      (is_prio ? (full_hit || partial_hit) : (full_hit && perm_ok));
   assign now_allow = is_prio ? (full_hit && perm_ok) : 1'b1;
   assign now_etype = partial_hit ? ETYPE_PARTIAL : perm_etype;
   assign np_deny   = entry_on && !is_prio && full_hit && !perm_ok;

`ifdef IOPMP_CHK_EARLY_EXIT_EN
   assign scan_done = dec_now || (idx == LAST_IDX);
`else
   assign scan_done = (idx == LAST_IDX);
`endif

   // Result if the scan ended this cycle; a latched decision always wins.
   always_comb begin
      fin_allow = 1'b0;
      fin_etype = ETYPE_NO_HIT;
      fin_eid   = '0;
      if (npd_found) begin
         fin_etype = npd_etype;
         fin_eid   = npd_eid;
      end else if (np_deny) begin
         fin_etype = perm_etype;
         fin_eid   = 16'(idx);
      end
      if (dec_now) begin
         fin_allow = now_allow;
         fin_etype = now_etype;
         fin_eid   = 16'(idx);
      end
      if (decided) begin
         fin_allow = dec_allow;
         fin_etype = dec_etype;
         fin_eid   = dec_eid;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= CHK_IDLE;
         idx       <= '0;
         rrid_q    <= '0;
         addr_q    <= '0;
         size_q    <= '0;
         type_q    <= '0;
         decided   <= 1'b0;
         dec_allow <= 1'b0;
         dec_etype <= '0;
         dec_eid   <= '0;
         npd_found <= 1'b0;
         npd_etype <= '0;
         npd_eid   <= '0;
         rsp_allow <= 1'b0;
         err_rep   <= '0;
      end else begin
         case (state)
            CHK_IDLE: if (req_valid_i) begin
               rrid_q    <= req_rrid_i;
               addr_q    <= req_addr_i;
               size_q    <= req_size_i;
               type_q    <= req_type_i;
               idx       <= '0;
               decided   <= 1'b0;
               npd_found <= 1'b0;
               if (req_rrid_i >= RRID_LIMIT) begin
                  state     <= CHK_RESP;
                  rsp_allow <= 1'b0;
                  err_rep   <= '{ttype: ttype_of(req_type_i), etype: ETYPE_UNKNOWN_RRID,
                                 rrid: 16'(req_rrid_i), eid: 16'd0, addr: req_addr_i};
               end else begin
                  state <= CHK_SCAN;
               end
            end
            CHK_SCAN: begin
               if (dec_now) begin
                  decided   <= 1'b1;
                  dec_allow <= now_allow;
                  dec_etype <= now_etype;
                  dec_eid   <= 16'(idx);
               end
               if (np_deny && !decided && !npd_found) begin
                  npd_found <= 1'b1;
                  npd_etype <= perm_etype;
                  npd_eid   <= 16'(idx);
               end
               if (scan_done) begin
                  state     <= CHK_RESP;
                  rsp_allow <= fin_allow;
                  if (!fin_allow)
                     err_rep <= '{ttype: ttype_of(type_q), etype: fin_etype,
                                  rrid: 16'(rrid_q), eid: fin_eid, addr: addr_q};
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            CHK_RESP: if (rsp_ready_i) state <= CHK_IDLE;
            default:  state <= CHK_IDLE;
         endcase
      end
   end

   // Lock bit and MD enables beyond the configured MD count are not consulted.
   assign unused_tables  = ^srcmd_en_table;

   assign req_ready_o    = (state == CHK_IDLE);
   assign busy_o         = (state != CHK_IDLE);
   assign rsp_valid_o    = (state == CHK_RESP);
   assign rsp_allow_o    = rsp_allow;
   assign err_valid_o    = (state == CHK_RESP) && rsp_ready_i && !rsp_allow;
   assign error_report_o = err_rep;

endmodule

// File: tb/tb_iopmp_rule_checker.sv
// Self-checking bench for iopmp_rule_checker: directed cases plus randomized tables checked against a rule model.
module tb_iopmp_rule_checker;
   import iopmp_pkg::*;

   localparam int NR = 16;
   localparam int NMD = 8;
   localparam int NM = 4;
`ifdef IOPMP_CHK_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic req_valid, req_ready, busy, rsp_valid, rsp_ready, rsp_allow, err_valid;
   logic [2:0]  req_rrid;
   logic [33:0] req_addr;
   logic [1:0]  req_size, req_type;
   entry_cfg_t [NR-1:0]        conf;
   logic [NR-1:0][33:0]        eaddr;
   logic [NMD-1:0][15:0]       mdcfg;
   logic [NM-1:0][31:0]        srcmd;
   logic [15:0]                prio;
   error_registers_t           err_rep, exp_err;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   iopmp_rule_checker #(.IOPMPRegions(NR), .IOPMPMemoryDomains(NMD), .NUM_MASTERS(NM)) dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_rrid_i(req_rrid), .req_addr_i(req_addr), .req_size_i(req_size), .req_type_i(req_type),
      .entry_conf_table(conf), .entry_addr_table(eaddr), .mdcfg_table(mdcfg),
      .srcmd_en_table(srcmd), .prio_entry_num(prio),
      .busy_o(busy), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_allow_o(rsp_allow), .err_valid_o(err_valid), .error_report_o(err_rep)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int lat_of(input int d);
      return EARLY ? d + 2 : NR + 1;
   endfunction

   // Behavioural reference written directly from the entry/MD/priority rules.
   function automatic void model(input int rrid, input logic [33:0] a, input int sz, input int typ,
                                 output bit allow, output int etype, output int eid, output int lat);
      longint first, last, lo, hi, e, sizeb;
      bit fi, li, perm, np_seen, done;
      int md, k, pet;
      first = longint'(a);
      last  = first + (longint'(1) << sz) - 1;
      pet   = (typ == 1) ? 2 : (typ == 2) ? 3 : 1;
      allow = 0; etype = 5; eid = 0; lat = NR + 1; np_seen = 0; done = 0;
      if (rrid >= NM) begin
         etype = 6;
         lat   = 1;
         return;
      end
      for (int j = 0; j < NR && !done; j++) begin
         md = -1;
         for (int m = NMD - 1; m >= 0; m--) if (j < int'(mdcfg[m])) md = m;
         if (conf[j].a == 2'd0 || md < 0) continue;
         if (!srcmd[rrid][md+1]) continue;
         e = longint'(eaddr[j]);
         case (conf[j].a)
            2'd1: begin
               lo = 0;
               if (j > 0) lo = longint'(eaddr[j-1]);
               hi = e;
            end
            2'd2: begin lo = e; hi = e + 4; end
            default: begin
               k = 0;
               while (k < 32 && e[k+2]) k++;
               sizeb = longint'(1) << (k + 3);
               lo = e & ~(sizeb - 1);
               hi = lo + sizeb;
            end
         endcase
         fi   = first >= lo && first < hi;
         li   = last < (longint'(1) << 34) && last >= lo && last < hi;
         perm = (typ == 1) ? conf[j].w : (typ == 2) ? conf[j].x : conf[j].r;
         if (j < int'(prio)) begin
            if (fi && li) begin allow = perm; etype = perm ? 0 : pet; eid = j; done = 1; end
            else if (fi != li) begin etype = 4; eid = j; done = 1; end
         end else if (fi && li) begin
            if (perm) begin allow = 1; done = 1; end
            else if (!np_seen) begin np_seen = 1; etype = pet; eid = j; end
         end
         if (done && EARLY) lat = j + 2;
      end
   endfunction

   task automatic txn(input string tag, input int rrid, input logic [33:0] a, input int sz, input int typ,
                      input bit eallow, input int eet, input int eeid, input int elat);
      int lat;
      int tt;
      tt = (typ == 1) ? 2 : (typ == 2) ? 3 : 1;
      @(negedge clk);
      check({tag, ".ready"}, 128'(req_ready), 128'(1));
      req_valid = 1'b1;
      req_rrid  = 3'(rrid);
      req_addr  = a;
      req_size  = 2'(sz);
      req_type  = 2'(typ);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 64) begin
         @(posedge clk);
         #1 lat++;
      end
      check({tag, ".lat"}, 128'(lat), 128'(elat));
      check({tag, ".allow"}, 128'(rsp_allow), 128'(eallow));
      if (!eallow)
         exp_err = '{ttype: 2'(tt), etype: 4'(eet), rrid: 16'(rrid), eid: 16'(eeid), addr: a};
      check({tag, ".err_rep"}, 128'(err_rep), 128'(exp_err));
      check({tag, ".errv_hold"}, 128'(err_valid), 128'(0));
      rsp_ready = 1'b1;
      #1 check({tag, ".errv"}, 128'(err_valid), 128'(!eallow));
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      check({tag, ".idle"}, 128'({req_ready, rsp_valid, busy, err_valid}), 128'(4'b1000));
   endtask

   task automatic rnd_txn(input int n);
      int rrid, sz, typ, eet, eeid, elat;
      bit eallow;
      logic [33:0] a;
      rrid = $urandom_range(0, NM);
      a    = 34'($urandom_range(0, 'h3400));
      sz   = $urandom_range(0, 3);
      typ  = $urandom_range(0, 3);
      model(rrid, a, sz, typ, eallow, eet, eeid, elat);
      txn($sformatf("rnd%0d", n), rrid, a, sz, typ, eallow, eet, eeid, elat);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      req_rrid = '0; req_addr = '0; req_size = '0; req_type = '0;
      conf = '0; eaddr = '0; mdcfg = '0; srcmd = '0; prio = '0; exp_err = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.ready", 128'(req_ready), 128'(1));
      check("rst.outs", 128'({rsp_valid, busy, rsp_allow, err_valid}), 128'(0));
      check("rst.err_rep", 128'(err_rep), 128'(0));
      @(negedge clk) reset = 1'b0;

      conf[0]  = '{a: MODE_TOR, x: 1'b0, w: 1'b0, r: 1'b1};
      eaddr[0] = 34'h1000;
      mdcfg[0] = 16'd1;
      for (int m = 1; m < NMD; m++) mdcfg[m] = 16'd16;
      srcmd[0] = 32'h2;
      srcmd[1] = 32'h4;
      txn("tor_rd",  0, 34'h100, 2, 0, 1, 0, 0, lat_of(0));
      txn("tor_wr",  0, 34'h100, 2, 1, 0, 2, 0, NR + 1);
      txn("tor_ex",  0, 34'h100, 2, 2, 0, 3, 0, NR + 1);
      txn("tor_end", 0, 34'hFFC, 3, 0, 0, 5, 0, NR + 1);

      prio     = 16'd1;
      conf[0]  = '{a: MODE_NA4, x: 1'b0, w: 1'b0, r: 1'b1};
      eaddr[0] = 34'hFFC;
      txn("na4_part", 0, 34'hFFC, 3, 0, 0, 4, 0, lat_of(0));
      txn("na4_full", 0, 34'hFFC, 2, 0, 1, 0, 0, lat_of(0));
      txn("unk_rrid", 4, 34'h100, 2, 0, 0, 6, 0, 1);

      prio     = 16'd0;
      conf[0]  = '{a: MODE_TOR, x: 1'b0, w: 1'b1, r: 1'b0};
      eaddr[0] = 34'h1000;
      txn("type3_rd", 0, 34'h200, 1, 3, 0, 1, 0, NR + 1);
      txn("md_off",   1, 34'h100, 2, 1, 0, 5, 0, NR + 1);

      // Abort a scan with reset; nothing is reported and the record clears.
      @(negedge clk);
      req_valid = 1'b1; req_rrid = 3'd1; req_addr = 34'h100; req_size = 2'd2; req_type = 2'd0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("scan.busy", 128'({busy, req_ready, rsp_valid}), 128'(3'b100));
      reset = 1'b1;
      #1 check("abort.outs", 128'({req_ready, busy, rsp_valid, err_valid}), 128'(4'b1000));
      check("abort.err_rep", 128'(err_rep), 128'(0));
      exp_err = '0;
      @(negedge clk) reset = 1'b0;

      conf[0]  = '{a: MODE_NAPOT, x: 1'b0, w: 1'b0, r: 1'b1};
      eaddr[0] = 34'h3_FFFF_FFFF;
      txn("ovf_in",   0, 34'h3_FFFF_FFFC, 2, 0, 1, 0, 0, lat_of(0));
      txn("ovf_nohit",0, 34'h3_FFFF_FFFC, 3, 0, 0, 5, 0, NR + 1);
      prio = 16'd1;
      txn("ovf_part", 0, 34'h3_FFFF_FFFC, 3, 0, 0, 4, 0, lat_of(0));

      for (int c = 0; c < 8; c++) begin
         for (int j = 0; j < NR; j++) begin
            conf[j]  = entry_cfg_t'(5'($urandom));
            eaddr[j] = 34'(j * 'h200 + $urandom_range(0, 'h3ff));
         end
         t = 0;
         for (int m = 0; m < NMD; m++) begin
            t = t + $urandom_range(0, 4);
            mdcfg[m] = 16'((t > NR) ? NR : t);
         end
         for (int r = 0; r < NM; r++) srcmd[r] = $urandom;
         prio = 16'($urandom_range(0, 6));
         for (int n = 0; n < 8; n++) rnd_txn(c * 8 + n);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
